weight_bank_buffer: RTL and testbench

WEIGHT_BANK_BUFFER -- requirements
Module: weight_bank_buffer

---
 rtl/weight_bank_buffer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_weight_bank_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_buffer.sv
// -----------------------------------------------------------------------------
// weight_bank_buffer
//   Five-bank weight store: bank 0 holds conv weights, banks 1..4 hold the
//   fc0..fc3 weights. A DMA engine fills the banks through per-bank
//   address/data pairs. A single read port returns one word per cycle with
//   one cycle of latency. Per-bank "loaded" flags gate reads, and a small FSM
//   (IDLE -> LOADING -> READY) reports when every bank holds valid data.
//
// Parameters
//   DW          weight data width
//   AW          write/read address width
//   DEPTH_LOG2  log2 of words per bank
//
// Ports
//   i_clk              clock, rising edge
//   i_rst              synchronous active-high reset
//   i_clear            clear load status / overflow, return to IDLE
//   i_dma_control[4:0] one-hot write bank select (bit0 conv, bits1..4 fc0..fc3)
//   i_write_en         DMA write strobe
//   i_conv_addr/data   conv bank write pair
//   i_fc_addr0..3      fc bank write addresses
//   i_fc_data0..3      fc bank write data
//   i_dma_finish       DMA done, marks bank 4 loaded
//   i_rd_req           read request
//   i_rd_bank[2:0]     read bank (0 conv, 1..4 fc0..fc3)
//   i_rd_addr          read address
//   o_rd_ready         read accepted this cycle (combinational)
//   o_rd_valid         read result valid (cycle after acceptance)
//   o_rd_data          read data, zero unless a good read completes
//   o_rd_err           with o_rd_valid, read was rejected
//   o_bank_loaded[4:0] per-bank loaded flags
//   o_all_loaded       high in READY
//   o_wr_overflow      sticky, a write address was out of range
//
// Optional feature
//   WEIGHT_BUF_BYPASS_EN  when defined, a read to the bank being written is
//                         accepted; on matching addresses the write data is
//                         forwarded to the read result.
// -----------------------------------------------------------------------------
module weight_bank_buffer #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 16,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic [4:0]    i_dma_control,
    input  logic          i_write_en,
    input  logic [AW-1:0] i_conv_addr,
    input  logic [DW-1:0] i_conv_data,
    input  logic [AW-1:0] i_fc_addr0,
    input  logic [DW-1:0] i_fc_data0,
    input  logic [AW-1:0] i_fc_addr1,
    input  logic [DW-1:0] i_fc_data1,
    input  logic [AW-1:0] i_fc_addr2,
    input  logic [DW-1:0] i_fc_data2,
    input  logic [AW-1:0] i_fc_addr3,
    input  logic [DW-1:0] i_fc_data3,
    input  logic          i_dma_finish,
    input  logic          i_rd_req,
    input  logic [2:0]    i_rd_bank,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_ready,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_err,
    output logic [4:0]    o_bank_loaded,
    output logic          o_all_loaded,
    output logic          o_wr_overflow
);

    localparam int unsigned NBANK = 5;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADING,
        ST_READY
    } state_e;

    // ---------------------------------------------------------------------
    // Storage (contents are never reset)
    // ---------------------------------------------------------------------
    logic [DW-1:0] bank_mem [NBANK][DEPTH];

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_e        state_q,    state_d;
    logic [3:0]    ctrl_q;
    logic          finish_q;
    logic [4:0]    loaded_q,   loaded_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_err_q,   rd_err_d;
    logic [DW-1:0] rd_data_q,  rd_data_d;

    // ---------------------------------------------------------------------
    // Write-side decode
    // ---------------------------------------------------------------------
    logic                  wr_onehot;
    logic [2:0]            wr_bank;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  wr_in_range;
    logic                  wr_fire;
    logic                  wr_accept;
    logic                  wr_oflow;

    // Only an exactly one-hot select picks a pair; anything else leaves
    // wr_onehot low so the write is dropped.
    always_comb begin
        wr_onehot = 1'b0;
        wr_bank   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        case (i_dma_control)
            5'b00001: begin
                wr_onehot = 1'b1; wr_bank = 3'd0;
                wr_addr = i_conv_addr; wr_data = i_conv_data;
            end
            5'b00010: begin
                wr_onehot = 1'b1; wr_bank = 3'd1;
                wr_addr = i_fc_addr0; wr_data = i_fc_data0;
            end
            5'b00100: begin
                wr_onehot = 1'b1; wr_bank = 3'd2;
                wr_addr = i_fc_addr1; wr_data = i_fc_data1;
            end
            5'b01000: begin
                wr_onehot = 1'b1; wr_bank = 3'd3;
                wr_addr = i_fc_addr2; wr_data = i_fc_data2;
            end
            5'b10000: begin
                wr_onehot = 1'b1; wr_bank = 3'd4;
                wr_addr = i_fc_addr3; wr_data = i_fc_data3;
            end
            default: ;
        endcase
    end

    assign wr_idx      = wr_addr[DEPTH_LOG2-1:0];
    assign wr_in_range = ((wr_addr >> DEPTH_LOG2) == '0);
    assign wr_fire     = i_write_en & wr_onehot;
    assign wr_accept   = wr_fire & wr_in_range;
    assign wr_oflow    = wr_fire & ~wr_in_range;

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            bank_mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    // ---------------------------------------------------------------------
    // Read-side decode
    // ---------------------------------------------------------------------
    logic                  rd_bank_ok;
    logic                  rd_in_range;
    logic [7:0]            loaded_ext;
    logic                  rd_bank_loaded;
    logic [2:0]            rd_bank_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_conflict;
    logic                  rd_ready;

    assign rd_bank_ok     = (i_rd_bank <= 3'd4);
    assign rd_in_range    = ((i_rd_addr >> DEPTH_LOG2) == '0);
    // Pad to 8 entries so banks 5..7 read as "not loaded" without an
    // out-of-range select.
    assign loaded_ext     = {3'b000, loaded_q};
    assign rd_bank_loaded = loaded_ext[i_rd_bank];
    assign rd_bank_idx    = rd_bank_ok ? i_rd_bank : 3'd0;
    assign rd_idx         = i_rd_addr[DEPTH_LOG2-1:0];
    assign rd_conflict    = wr_fire & (wr_bank == i_rd_bank);

`ifdef WEIGHT_BUF_BYPASS_EN
    assign rd_ready = i_rd_req & ~i_rst;
`else
    // A write to the same bank owns the port this cycle.
    assign rd_ready = i_rd_req & ~i_rst & ~rd_conflict;
`endif

    assign o_rd_ready = rd_ready;

    always_comb begin
        rd_valid_d = rd_ready;
        rd_err_d   = 1'b0;
        rd_data_d  = '0;
        if (rd_ready) begin
            if (!rd_bank_ok || !rd_in_range || !rd_bank_loaded) begin
                rd_err_d = 1'b1;
            end else begin
                rd_data_d = bank_mem[rd_bank_idx][rd_idx];
`ifdef WEIGHT_BUF_BYPASS_EN
                // Both addresses are in range here, so equal low bits
                // means equal full addresses.
                if (rd_conflict && wr_accept && (wr_idx == rd_idx)) begin
                    rd_data_d = wr_data;
                end
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // Load status and overflow
    // ---------------------------------------------------------------------
    logic [3:0] ctrl_fall;
    logic       finish_rise;

    assign ctrl_fall   = ctrl_q & ~i_dma_control[3:0];
    assign finish_rise = i_dma_finish & ~finish_q;

    always_comb begin
        loaded_d   = loaded_q;
        overflow_d = overflow_q;
        if (i_clear) begin
            loaded_d   = '0;
            overflow_d = 1'b0;
        end else begin
            loaded_d[3:0] = loaded_q[3:0] | ctrl_fall;
            loaded_d[4]   = loaded_q[4] | finish_rise;
            overflow_d    = overflow_q | wr_oflow;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (wr_accept)        state_d = ST_LOADING;
            ST_LOADING: if (loaded_q == '1)   state_d = ST_READY;
            ST_READY:   state_d = ST_READY;
            default:    state_d = ST_IDLE;
        endcase
        // A write coinciding with clear still lands in storage but must
        // not move the FSM out of IDLE.
        if (i_clear) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        o_all_loaded = (state_q == ST_READY);
    end

    // ---------------------------------------------------------------------
    // Status / read pipeline registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_q     <= '0;
            finish_q   <= 1'b0;
            loaded_q   <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            ctrl_q     <= i_dma_control[3:0];
            finish_q   <= i_dma_finish;
            loaded_q   <= loaded_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign o_rd_valid    = rd_valid_q;
    assign o_rd_err      = rd_err_q;
    assign o_rd_data     = rd_data_q;
    assign o_bank_loaded = loaded_q;
    assign o_wr_overflow = overflow_q;

endmodule

// File: tb/tb_weight_bank_buffer.sv
// -----------------------------------------------------------------------------
// tb_weight_bank_buffer
//   Directed, table-driven bench for weight_bank_buffer. Each record is one
//   clock cycle: the inputs for that cycle, the expected o_rd_ready during
//   it, and the expected registered outputs after its rising edge.
// -----------------------------------------------------------------------------
module tb_weight_bank_buffer;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst, clr, we, fin, rq;
    logic [4:0]    ctrl;
    logic [AW-1:0] conv_addr, fc_addr0, fc_addr1, fc_addr2, fc_addr3, rd_addr;
    logic [DW-1:0] conv_data, fc_data0, fc_data1, fc_data2, fc_data3;
    logic [2:0]    rd_bank;
    logic          rd_ready, rd_valid, rd_err, all_loaded, wr_overflow;
    logic [DW-1:0] rd_data;
    logic [4:0]    bank_loaded;

    always #5 clk = ~clk;

    weight_bank_buffer #(.DW(DW), .AW(AW), .DEPTH_LOG2(10)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (clr),
        .i_dma_control(ctrl),
        .i_write_en   (we),
        .i_conv_addr  (conv_addr),
        .i_conv_data  (conv_data),
        .i_fc_addr0   (fc_addr0),
        .i_fc_data0   (fc_data0),
        .i_fc_addr1   (fc_addr1),
        .i_fc_data1   (fc_data1),
        .i_fc_addr2   (fc_addr2),
        .i_fc_data2   (fc_data2),
        .i_fc_addr3   (fc_addr3),
        .i_fc_data3   (fc_data3),
        .i_dma_finish (fin),
        .i_rd_req     (rq),
        .i_rd_bank    (rd_bank),
        .i_rd_addr    (rd_addr),
        .o_rd_ready   (rd_ready),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_rd_err     (rd_err),
        .o_bank_loaded(bank_loaded),
        .o_all_loaded (all_loaded),
        .o_wr_overflow(wr_overflow)
    );

    typedef struct {
        logic        rst;
        logic        clr;
        logic [4:0]  ctrl;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic        fin;
        logic        rq;
        logic [2:0]  rb;
        logic [15:0] ra;
        logic        x_rdy;
        logic        x_vld;
        logic        x_err;
        logic [15:0] x_dat;
        logic [4:0]  x_ld;
        logic        x_all;
        logic        x_ovf;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(
        input logic rst_, input logic clr_, input logic [4:0] ctrl_,
        input logic we_, input logic [15:0] addr_, input logic [15:0] data_,
        input logic fin_, input logic rq_, input logic [2:0] rb_,
        input logic [15:0] ra_, input logic x_rdy_, input logic x_vld_,
        input logic x_err_, input logic [15:0] x_dat_, input logic [4:0] x_ld_,
        input logic x_all_, input logic x_ovf_);
        vec_t v;
        v.rst = rst_; v.clr = clr_; v.ctrl = ctrl_; v.we = we_;
        v.addr = addr_; v.data = data_; v.fin = fin_; v.rq = rq_;
        v.rb = rb_; v.ra = ra_; v.x_rdy = x_rdy_; v.x_vld = x_vld_;
        v.x_err = x_err_; v.x_dat = x_dat_; v.x_ld = x_ld_;
        v.x_all = x_all_; v.x_ovf = x_ovf_;
        return v;
    endfunction

    // The selected pair(s) carry addr/data; unselected pairs carry
    // different values so a wrong pair choice shows up in storage.
    task automatic run_vec(input vec_t v, input string tag);
        logic got_rdy;
        rst  = v.rst;  clr = v.clr; ctrl = v.ctrl; we = v.we; fin = v.fin;
        rq   = v.rq;   rd_bank = v.rb; rd_addr = v.ra;
        conv_addr = v.ctrl[0] ? v.addr : (v.addr ^ 16'h0001);
        conv_data = v.ctrl[0] ? v.data : ~v.data;
        fc_addr0  = v.ctrl[1] ? v.addr : (v.addr ^ 16'h0001);
        fc_data0  = v.ctrl[1] ? v.data : ~v.data;
        fc_addr1  = v.ctrl[2] ? v.addr : (v.addr ^ 16'h0001);
        fc_data1  = v.ctrl[2] ? v.data : ~v.data;
        fc_addr2  = v.ctrl[3] ? v.addr : (v.addr ^ 16'h0001);
        fc_data2  = v.ctrl[3] ? v.data : ~v.data;
        fc_addr3  = v.ctrl[4] ? v.addr : (v.addr ^ 16'h0001);
        fc_data3  = v.ctrl[4] ? v.data : ~v.data;
        #1;
        got_rdy = rd_ready;
        @(posedge clk);
        #1;
        n_vec++;
        if (got_rdy !== v.x_rdy || rd_valid !== v.x_vld || rd_err !== v.x_err ||
            rd_data !== v.x_dat || bank_loaded !== v.x_ld ||
            all_loaded !== v.x_all || wr_overflow !== v.x_ovf) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b vld=%b err=%b dat=%h ld=%b all=%b ovf=%b, want rdy=%b vld=%b err=%b dat=%h ld=%b all=%b ovf=%b",
                     tag, got_rdy, rd_valid, rd_err, rd_data, bank_loaded, all_loaded, wr_overflow,
                     v.x_rdy, v.x_vld, v.x_err, v.x_dat, v.x_ld, v.x_all, v.x_ovf);
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] wval(input int b, input int a);
        if (b == 0) return 16'(16'h100 + a);
        return 16'(16'h200 * (b + 1) + a);
    endfunction

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    initial begin
        logic [4:0] eld;

        //                  rst clr ctrl    we addr     data     fin rq rb ra       rdy vld err dat      ld      all ovf
        // idle reads, early read, edge-detected load flags, clear
        tbl_a.push_back(mk(1, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 1, 16'h0000, 5'h00, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h02, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000, 1, 1, 1, 16'h0000, 5'h00, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h02, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0400, 1, 1, 1, 16'h0000, 5'h02, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 5, 16'h0000, 1, 1, 1, 16'h0000, 5'h02, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 7, 16'h0000, 1, 1, 1, 16'h0000, 5'h02, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h12, 0, 0));
        tbl_a.push_back(mk(0, 1, 5'h00, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0));
        tbl_a.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0));

        // reads after full load, overflow, dropped non-one-hot write, conflict
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 2, 16'h0003, 1, 1, 0, 16'h0603, 5'h1F, 1, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0009, 1, 1, 0, 16'h0109, 5'h1F, 1, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 4, 16'h0000, 1, 1, 0, 16'h0A00, 5'h1F, 1, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 3, 16'h0400, 1, 1, 1, 16'h0000, 5'h1F, 1, 0));
        tbl_b.push_back(mk(0, 0, 5'h01, 1, 16'h0400, 16'hDEAD, 0, 1, 2, 16'h0005, 1, 1, 0, 16'h0605, 5'h1F, 1, 1));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 0, 16'h0100, 5'h1F, 1, 1));
        tbl_b.push_back(mk(0, 0, 5'h03, 1, 16'h0003, 16'h1111, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h1F, 1, 1));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0003, 1, 1, 0, 16'h0103, 5'h1F, 1, 1));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0003, 1, 1, 0, 16'h0403, 5'h1F, 1, 1));
`ifdef WEIGHT_BUF_BYPASS_EN
        tbl_b.push_back(mk(0, 0, 5'h02, 1, 16'h0005, 16'hABCD, 0, 1, 1, 16'h0005, 1, 1, 0, 16'hABCD, 5'h1F, 1, 1));
`else
        tbl_b.push_back(mk(0, 0, 5'h02, 1, 16'h0005, 16'hABCD, 0, 1, 1, 16'h0005, 0, 0, 0, 16'h0000, 5'h1F, 1, 1));
`endif
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0005, 1, 1, 0, 16'hABCD, 5'h1F, 1, 1));
        // clear, then write-with-clear must leave the FSM in IDLE
        tbl_b.push_back(mk(0, 1, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 1, 16'h0000, 5'h00, 0, 0));
        tbl_b.push_back(mk(0, 1, 5'h01, 1, 16'h0007, 16'h7777, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h01, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0007, 1, 1, 0, 16'h7777, 5'h01, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h0E, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h11, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h1F, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h1F, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 4, 16'h0009, 1, 1, 0, 16'h0A09, 5'h1F, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h04, 1, 16'h0000, 16'h0600, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h1F, 0, 0));
        tbl_b.push_back(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h1F, 1, 0));

        // power-on reset (unchecked: outputs are undefined before it)
        rst = 1'b1; clr = 1'b0; ctrl = '0; we = 1'b0; fin = 1'b0; rq = 1'b0;
        rd_bank = '0; rd_addr = '0;
        conv_addr = '0; conv_data = '0;
        fc_addr0 = '0; fc_data0 = '0; fc_addr1 = '0; fc_data1 = '0;
        fc_addr2 = '0; fc_data2 = '0; fc_addr3 = '0; fc_data3 = '0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < tbl_a.size(); i++) run_vec(tbl_a[i], $sformatf("a%0d", i));

        // full load: each bank written 0..9, then its control bit drops
        eld = 5'h00;
        for (int b = 0; b < 5; b++) begin
            for (int a = 0; a < 10; a++) begin
                run_vec(mk(0, 0, 5'(1 << b), 1, 16'(a), wval(b, a), 0, 0, 0, 16'h0000,
                           0, 0, 0, 16'h0000, eld, 0, 0), $sformatf("load b%0d a%0d", b, a));
            end
            if (b < 4) begin
                eld = eld | 5'(1 << b);
                run_vec(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000,
                           0, 0, 0, 16'h0000, eld, 0, 0), $sformatf("fall b%0d", b));
            end else begin
                eld = 5'h1F;
                run_vec(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000,
                           0, 0, 0, 16'h0000, eld, 0, 0), "finish");
            end
        end
        run_vec(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000,
                   0, 0, 0, 16'h0000, 5'h1F, 1, 0), "ready");

        for (int i = 0; i < tbl_b.size(); i++) run_vec(tbl_b[i], $sformatf("b%0d", i));

        // reset during bank 2 load with a read in flight
        run_vec(mk(0, 1, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0), "r clear");
        run_vec(mk(0, 0, 5'h04, 1, 16'h0500, 16'h1234, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h10, 0, 1), "r ovf");
        run_vec(mk(0, 0, 5'h04, 1, 16'h0000, 16'h0600, 0, 1, 0, 16'h0000, 1, 1, 1, 16'h0000, 5'h10, 0, 1), "r read");
        run_vec(mk(1, 0, 5'h04, 1, 16'h0001, 16'h0601, 0, 1, 1, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0), "r reset");
        run_vec(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 5'h00, 0, 0), "r after");
        run_vec(mk(0, 0, 5'h00, 0, 16'h0000, 16'h0000, 0, 1, 2, 16'h0000, 1, 1, 1, 16'h0000, 5'h00, 0, 0), "r unloaded");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
